huffman_lut_encoder: RTL and testbench

Huffman symbol encoder core. A 64-entry codeword look-up RAM is followed by a bit packer. The RAM holds one {length, code} pair per 6-bit symbol. The packer concatenates variable-length codes MSB-first into 32-bit words and pulses a strobe for each completed word. It sits behind the Avalon-MM wrapper, which supplies mode, address and write data; the packed words are exported outside the system.

---
 rtl/huffman_pkg.sv | 20 ++
 rtl/huffman_lut_ram.sv | 30 +++
 rtl/huffman_lut_encoder.sv | 111 +++++++++++
 tb/tb_huffman_lut_encoder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// Shared widths and the codeword layout for the Huffman LUT encoder.
package huffman_pkg;

   localparam int unsigned ADDR_W  = 6;
   localparam int unsigned CODE_W  = 8;
   localparam int unsigned LEN_W   = 4;
   localparam int unsigned OUT_W   = 32;
   localparam int unsigned MAX_LEN = 8;
   localparam int unsigned ENTRY_W = LEN_W + CODE_W;
   localparam int unsigned DEPTH   = 1 << ADDR_W;
   localparam int unsigned CNT_W   = $clog2(OUT_W);
   localparam int unsigned SUM_W   = CNT_W + 1;
   localparam int unsigned WIN_W   = OUT_W + CODE_W;

   typedef struct packed {
      logic [LEN_W-1:0]  len;
      logic [CODE_W-1:0] code;
   } codeword_t;

endpackage

// File: rtl/huffman_lut_ram.sv
// 64x12 single-port codeword RAM; write when we=1, registered read otherwise.
module huffman_lut_ram
   import huffman_pkg::*;
(
   input  logic               clock,
   input  logic               resetn,
   input  logic               we,
   input  logic [ADDR_W-1:0]  addr,
   input  logic [ENTRY_W-1:0] wdata,
   output logic [ENTRY_W-1:0] rdata
);

   logic [ENTRY_W-1:0] mem [DEPTH];

   // Storage array carries no reset so it maps onto a RAM macro.
   always_ff @(posedge clock) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rdata <= '0;
      end else if (!we) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/huffman_lut_encoder.sv
// Huffman encoder: codeword LUT followed by an MSB-first 32-bit bit packer.
module huffman_lut_encoder
   import huffman_pkg::*;
(
   input  logic               clock,
   input  logic               resetn,
   input  logic               modeselect,
   input  logic [ADDR_W-1:0]  addr,
   input  logic [ENTRY_W-1:0] data,
   input  logic               sym_valid,
   input  logic               flush,
   output logic [ENTRY_W-1:0] codeword_out,
   output logic [OUT_W-1:0]   encoded_out,
   output logic               enable_out
);

   logic             s1_valid;
   logic             flush_pending, flush_pending_n;
   logic [OUT_W-1:0] buffer, buffer_n;
   logic [CNT_W-1:0] count, count_n;
   logic [OUT_W-1:0] encoded_n;
   logic             enable_n;

   codeword_t        cw;
   logic             sym_ok;
   logic [CODE_W-1:0] code_aligned;
   logic [WIN_W-1:0] window;
   logic [SUM_W-1:0] sum;

   huffman_lut_ram u_ram (
      .clock  (clock),
      .resetn (resetn),
      .we     (modeselect),
      .addr   (addr),
      .wdata  (data),
      .rdata  (codeword_out)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= sym_valid & ~modeselect;
      end
   end

   // Code bits left-aligned in an 8-bit field, then placed just below the buffered bits.
   assign cw           = codeword_t'(codeword_out);
   assign sym_ok       = s1_valid && (cw.len != '0) && (cw.len <= LEN_W'(MAX_LEN));
   assign code_aligned = cw.code << (LEN_W'(MAX_LEN) - cw.len);
   assign window       = {buffer, {CODE_W{1'b0}}} | ({code_aligned, {OUT_W{1'b0}}} >> count);
   assign sum          = SUM_W'(count) + SUM_W'(cw.len);

   always_comb begin
      buffer_n        = buffer;
      count_n         = count;
      encoded_n       = encoded_out;
      enable_n        = 1'b0;
      flush_pending_n = 1'b0;

      if (flush_pending) begin
         // Deferred flush; any symbol landing now starts the next word.
         if (count != '0) begin
            encoded_n = buffer;
            enable_n  = 1'b1;
         end
         buffer_n = '0;
         count_n  = '0;
         if (sym_ok) begin
            buffer_n = {code_aligned, {(OUT_W-CODE_W){1'b0}}};
            count_n  = CNT_W'(cw.len);
         end
         flush_pending_n = flush & s1_valid;
      end else if (s1_valid) begin
         if (sym_ok) begin
            if (sum >= SUM_W'(OUT_W)) begin
               encoded_n = window[WIN_W-1 -: OUT_W];
               enable_n  = 1'b1;
               buffer_n  = {window[CODE_W-1:0], {(OUT_W-CODE_W){1'b0}}};
               count_n   = CNT_W'(sum - SUM_W'(OUT_W));
            end else begin
               buffer_n = window[WIN_W-1 -: OUT_W];
               count_n  = CNT_W'(sum);
            end
         end
         flush_pending_n = flush;
      end else if (flush && (count != '0)) begin
         encoded_n = buffer;
         enable_n  = 1'b1;
         buffer_n  = '0;
         count_n   = '0;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         buffer        <= '0;
         count         <= '0;
         encoded_out   <= '0;
         enable_out    <= 1'b0;
         flush_pending <= 1'b0;
      end else begin
         buffer        <= buffer_n;
         count         <= count_n;
         encoded_out   <= encoded_n;
         enable_out    <= enable_n;
         flush_pending <= flush_pending_n;
      end
   end

endmodule

// File: tb/tb_huffman_lut_encoder.sv
// Directed bench for huffman_lut_encoder with hand-computed expectations.
module tb_huffman_lut_encoder;

   logic        clock = 1'b0;
   logic        resetn;
   logic        modeselect;
   logic [5:0]  addr;
   logic [11:0] data;
   logic        sym_valid;
   logic        flush;
   logic [11:0] codeword_out;
   logic [31:0] encoded_out;
   logic        enable_out;

   int vectors = 0;
   int miscompares = 0;
   int pulses = 0;
   logic [31:0] last_word = '0;

   huffman_lut_encoder dut (
      .clock        (clock),
      .resetn       (resetn),
      .modeselect   (modeselect),
      .addr         (addr),
      .data         (data),
      .sym_valid    (sym_valid),
      .flush        (flush),
      .codeword_out (codeword_out),
      .encoded_out  (encoded_out),
      .enable_out   (enable_out)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock edge; outputs sampled 1ns later, strobes tallied.
   task automatic tick();
      @(posedge clock);
      #1;
      if (enable_out === 1'b1) begin
         pulses++;
         last_word = encoded_out;
      end
   endtask

   task automatic idle();
      modeselect = 1'b0; sym_valid = 1'b0; flush = 1'b0;
      tick();
   endtask

   task automatic wr(input logic [5:0] a, input logic [11:0] d);
      modeselect = 1'b1; addr = a; data = d; sym_valid = 1'b1; flush = 1'b0;
      tick();
   endtask

   task automatic sym(input logic [5:0] a);
      modeselect = 1'b0; addr = a; sym_valid = 1'b1; flush = 1'b0;
      tick();
   endtask

   task automatic do_flush();
      modeselect = 1'b0; sym_valid = 1'b0; flush = 1'b1;
      tick();
   endtask

   initial begin
      resetn = 1'b0; modeselect = 1'b0; addr = '0; data = '0; sym_valid = 1'b0; flush = 1'b0;
      tick(); tick();
      check("reset_encoded", encoded_out, 32'h0);
      check("reset_enable", 32'(enable_out), 32'h0);
      check("reset_codeword", 32'(codeword_out), 32'h0);
      #2 resetn = 1'b1;

      // Write / readback; sym_valid during the write must not reach the packer.
      wr(6'd5, 12'h305);
      check("write_keeps_codeword", 32'(codeword_out), 32'h0);
      idle();
      check("write_sym_ignored", 32'(enable_out), 32'h0);
      modeselect = 1'b0; addr = 6'd5; sym_valid = 1'b0; tick();
      check("readback_addr5", 32'(codeword_out), 32'h305);

      wr(6'd1, 12'h40A);
      wr(6'd2, 12'h77F);
      wr(6'd3, 12'h0FF);
      wr(6'd4, 12'h9FF);
      idle();

      // Exact fill: 8 x 4 bits of 1010.
      pulses = 0;
      for (int i = 0; i < 8; i++) sym(6'd1);
      check("fill_no_early_pulse", 32'(pulses), 32'd0);
      idle();
      check("fill_enable", 32'(enable_out), 32'h1);
      check("fill_word", encoded_out, 32'hAAAAAAAA);
      idle();
      check("fill_strobe_one_cycle", 32'(enable_out), 32'h0);
      do_flush(); idle();
      check("fill_count_zero_flush", 32'(pulses), 32'd1);

      // Overflow carry: 5 x 7 ones = 35 bits.
      pulses = 0;
      for (int i = 0; i < 5; i++) sym(6'd2);
      idle();
      check("ovf_enable", 32'(enable_out), 32'h1);
      check("ovf_word", encoded_out, 32'hFFFFFFFF);
      do_flush();
      check("ovf_flush_enable", 32'(enable_out), 32'h1);
      check("ovf_flush_word", encoded_out, 32'hE0000000);
      idle();
      check("ovf_hold_word", encoded_out, 32'hE0000000);
      check("ovf_pulses", 32'(pulses), 32'd2);

      // No-op lengths interleaved with eight addr-1 symbols.
      pulses = 0;
      sym(6'd1); sym(6'd3); sym(6'd1); sym(6'd4); sym(6'd1); sym(6'd1);
      sym(6'd3); sym(6'd1); sym(6'd1); sym(6'd4); sym(6'd1); sym(6'd1);
      idle();
      check("noop_enable", 32'(enable_out), 32'h1);
      check("noop_word", encoded_out, 32'hAAAAAAAA);
      do_flush(); idle();
      check("noop_pulses", 32'(pulses), 32'd1);

      // Flush with count=0.
      pulses = 0;
      do_flush(); idle();
      check("flush_empty_no_pulse", 32'(pulses), 32'd0);

      // Flush coinciding with a stage-1 symbol.
      sym(6'd1); sym(6'd1);
      do_flush();
      check("flush_s1_deferred", 32'(enable_out), 32'h0);
      idle();
      check("flush_s1_enable", 32'(enable_out), 32'h1);
      check("flush_s1_word", encoded_out, 32'hAA000000);
      idle();
      check("flush_s1_single", 32'(pulses), 32'd1);

      // Asynchronous reset mid-word.
      sym(6'd2); sym(6'd2); sym(6'd2); idle();
      #2 resetn = 1'b0;
      #1;
      check("rst_async_encoded", encoded_out, 32'h0);
      check("rst_async_enable", 32'(enable_out), 32'h0);
      check("rst_async_codeword", 32'(codeword_out), 32'h0);
      #1 resetn = 1'b1;
      pulses = 0;
      do_flush(); idle(); idle();
      check("rst_flush_no_pulse", 32'(pulses), 32'd0);
      check("rst_encoded_stays", encoded_out, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
